controle_rega: RTL and testbench

CONTROLE_REGA -- requirements
Module: controle_rega

---
 rtl/rega_pkg.sv | 24 ++
 rtl/filtro_sensor.sv | 45 ++++
 rtl/controle_rega.sv | 171 +++++++++++++++++
 tb/tb_controle_rega.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation controller: state encoding, default
// periods and the tank-level consistency rule.
package rega_pkg;

    typedef enum logic [2:0] {
        StOcioso     = 3'd0,
        StGotejando  = 3'd1,
        StAspersando = 3'd2,
        StPausa      = 3'd3,
        StFalha      = 3'd4
    } estado_t;

    localparam int unsigned TempoGotejoDef   = 30;
    localparam int unsigned TempoAspersaoDef = 10;
    localparam int unsigned TempoPausaDef    = 20;
    localparam int unsigned FiltroDef        = 3;

    // Water above a level implies water at every level below it.
    function automatic logic nivel_inconsistente(input logic high, input logic mediun,
                                                 input logic low);
        return (high & ~mediun) | (mediun & ~low);
    endfunction

endpackage

// File: rtl/filtro_sensor.sv
// Tank-level sensor filter: flags critical level, debounces level
// inconsistencies over FILTRO consecutive clocks and latches erro until cleared.
module filtro_sensor
    import rega_pkg::*;
#(
    parameter int unsigned FILTRO = FiltroDef
) (
    input  logic clock,
    input  logic reset,
    input  logic high,
    input  logic mediun,
    input  logic low,
    input  logic limpar,
    output logic inconsistente,
    output logic critico,
    output logic erro
);

    localparam logic [4:0] Limite = 5'(FILTRO);

    logic [3:0] contagem_q;
    logic       erro_q;

    assign inconsistente = nivel_inconsistente(high, mediun, low);
    assign critico       = ~low;
    assign erro          = erro_q;

    // Run-length count of inconsistent clocks; erro latches once the run reaches FILTRO.
    always_ff @(posedge clock) begin
        if (reset || limpar) begin
            contagem_q <= 4'd0;
            erro_q     <= 1'b0;
        end else if (inconsistente) begin
            if (contagem_q != 4'hF) begin
                contagem_q <= contagem_q + 4'd1;
            end
            if (({1'b0, contagem_q} + 5'd1) >= Limite) begin
                erro_q <= 1'b1;
            end
        end else begin
            contagem_q <= 4'd0;
        end
    end

endmodule

// File: rtl/controle_rega.sv
// Irrigation controller: chooses drip or sprinkler watering from air/soil/
// temperature sensors, enforces a rest period and handles tank-level faults.
// Optional feature: define REGA_CONTADOR_CICLOS_EN to add the ciclosRega
// completed-watering counter output.
module controle_rega
    import rega_pkg::*;
#(
    parameter int unsigned TEMPO_GOTEJO   = TempoGotejoDef,
    parameter int unsigned TEMPO_ASPERSAO = TempoAspersaoDef,
    parameter int unsigned TEMPO_PAUSA    = TempoPausaDef,
    parameter int unsigned FILTRO         = FiltroDef
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tickSegundo,
    input  logic       umidadeAr,
    input  logic       umidadeSolo,
    input  logic       temperatura,
    input  logic       high,
    input  logic       mediun,
    input  logic       low,
    input  logic       reconhecer,
    output logic       gotejamento,
    output logic       aspersao,
    output logic       valvulaEntrada,
    output logic       erro,
    output logic       alarme,
    output logic [2:0] estado,
    output logic [7:0] tempoRestante
`ifdef REGA_CONTADOR_CICLOS_EN
    ,
    output logic [15:0] ciclosRega
`endif
);

    localparam logic [7:0] PerGotejo   = 8'(TEMPO_GOTEJO);
    localparam logic [7:0] PerAspersao = 8'(TEMPO_ASPERSAO);
    localparam logic [7:0] PerPausa    = 8'(TEMPO_PAUSA);

    estado_t    estado_q, estado_d;
    logic [7:0] tempo_q, tempo_d;
    logic       gotejamento_q, aspersao_q, valvula_q, alarme_q;
    logic       gotejamento_d, aspersao_d, valvula_d, alarme_d;
    logic       inconsistente, critico, limpar;

    filtro_sensor #(
        .FILTRO(FILTRO)
    ) u_filtro (
        .clock        (clock),
        .reset        (reset),
        .high         (high),
        .mediun       (mediun),
        .low          (low),
        .limpar       (limpar),
        .inconsistente(inconsistente),
        .critico      (critico),
        .erro         (erro)
    );

    // State and timer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= StOcioso;
            tempo_q  <= 8'd0;
        end else begin
            estado_q <= estado_d;
            tempo_q  <= tempo_d;
        end
    end

    // Next state; the if-chain order encodes the same-edge priority.
    always_comb begin
        estado_d = estado_q;
        tempo_d  = tempo_q;
        limpar   = 1'b0;
        if (estado_q == StFalha) begin
            tempo_d = 8'd0;
            if (reconhecer && !inconsistente) begin
                estado_d = StOcioso;
                limpar   = 1'b1;
            end
        end else if (erro) begin
            estado_d = StFalha;
            tempo_d  = 8'd0;
        end else begin
            case (estado_q)
                StOcioso: begin
                    if (!umidadeSolo && !alarme_q) begin
                        if (!umidadeAr || (mediun && !temperatura)) begin
                            estado_d = StAspersando;
                            tempo_d  = PerAspersao;
                        end else begin
                            estado_d = StGotejando;
                            tempo_d  = PerGotejo;
                        end
                    end
                end
                StGotejando, StAspersando: begin
                    if (critico || umidadeSolo || (tickSegundo && tempo_q == 8'd1)) begin
                        estado_d = StPausa;
                        tempo_d  = PerPausa;
                    end else if (tickSegundo && tempo_q != 8'd0) begin
                        tempo_d = tempo_q - 8'd1;
                    end
                end
                StPausa: begin
                    if (tickSegundo && tempo_q == 8'd1) begin
                        estado_d = StOcioso;
                        tempo_d  = 8'd0;
                    end else if (tickSegundo && tempo_q != 8'd0) begin
                        tempo_d = tempo_q - 8'd1;
                    end
                end
                default: begin
                    estado_d = StOcioso;
                    tempo_d  = 8'd0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so registered outputs track estado.
    always_comb begin
        gotejamento_d = (estado_d == StGotejando);
        aspersao_d    = (estado_d == StAspersando);
        valvula_d     = ~high & ~erro & (estado_d != StFalha);
        alarme_d      = erro | critico;
    end

    // Registered drive outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            gotejamento_q <= 1'b0;
            aspersao_q    <= 1'b0;
            valvula_q     <= 1'b0;
            alarme_q      <= 1'b0;
        end else begin
            gotejamento_q <= gotejamento_d;
            aspersao_q    <= aspersao_d;
            valvula_q     <= valvula_d;
            alarme_q      <= alarme_d;
        end
    end

    assign gotejamento    = gotejamento_q;
    assign aspersao       = aspersao_q;
    assign valvulaEntrada = valvula_q;
    assign alarme         = alarme_q;
    assign estado         = estado_q;
    assign tempoRestante  = tempo_q;

`ifdef REGA_CONTADOR_CICLOS_EN
    logic [15:0] ciclos_q;
    logic        fim_rega;

    assign fim_rega = ((estado_q == StGotejando) || (estado_q == StAspersando))
                      && (estado_d == StPausa);

    // Saturating count of watering periods that ended in a rest.
    always_ff @(posedge clock) begin
        if (reset) begin
            ciclos_q <= 16'd0;
        end else if (fim_rega && ciclos_q != 16'hFFFF) begin
            ciclos_q <= ciclos_q + 16'd1;
        end
    end

    assign ciclosRega = ciclos_q;
`endif

endmodule

// File: tb/tb_controle_rega.sv
// Self-checking bench for controle_rega: directed scenarios plus randomized
// stimulus compared against a behavioural model of the controller rules.
module tb_controle_rega;

    localparam int TG = 3;
    localparam int TA = 5;
    localparam int TP = 2;
    localparam int FL = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tickSegundo = 1'b0;
    logic umidadeAr = 1'b1, umidadeSolo = 1'b1, temperatura = 1'b1;
    logic high = 1'b1, mediun = 1'b1, low = 1'b1;
    logic reconhecer = 1'b0;
    logic gotejamento, aspersao, valvulaEntrada, erro, alarme;
    logic [2:0] estado;
    logic [7:0] tempoRestante;
`ifdef REGA_CONTADOR_CICLOS_EN
    logic [15:0] ciclosRega;
`endif

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int m_estado, m_tempo, m_run, m_ciclos;
    bit m_erro, m_alarme, m_valv;

    controle_rega #(
        .TEMPO_GOTEJO  (TG),
        .TEMPO_ASPERSAO(TA),
        .TEMPO_PAUSA   (TP),
        .FILTRO        (FL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .tickSegundo   (tickSegundo),
        .umidadeAr     (umidadeAr),
        .umidadeSolo   (umidadeSolo),
        .temperatura   (temperatura),
        .high          (high),
        .mediun        (mediun),
        .low           (low),
        .reconhecer    (reconhecer),
        .gotejamento   (gotejamento),
        .aspersao      (aspersao),
        .valvulaEntrada(valvulaEntrada),
        .erro          (erro),
        .alarme        (alarme),
        .estado        (estado),
        .tempoRestante (tempoRestante)
`ifdef REGA_CONTADOR_CICLOS_EN
        ,
        .ciclosRega    (ciclosRega)
`endif
    );

    always #5 clock = ~clock;

    // Apply the controller rules to the inputs present at this edge.
    task automatic model_update();
        int ne, nt;
        bit incons, crit, sai;
        if (reset) begin
            m_estado = 0; m_tempo = 0; m_run = 0; m_ciclos = 0;
            m_erro = 0; m_alarme = 0; m_valv = 0;
            return;
        end
        incons = (high && !mediun) || (mediun && !low);
        crit   = !low;
        sai    = (m_estado == 4) && reconhecer && !incons;
        ne = m_estado;
        nt = m_tempo;
        if (m_estado == 4) begin
            nt = 0;
            if (sai) ne = 0;
        end else if (m_erro) begin
            ne = 4; nt = 0;
        end else if (m_estado == 0) begin
            if (!umidadeSolo && !m_alarme) begin
                if (!umidadeAr || (mediun && !temperatura)) begin ne = 2; nt = TA; end
                else begin ne = 1; nt = TG; end
            end
        end else if (m_estado == 1 || m_estado == 2) begin
            if (crit || umidadeSolo || (tickSegundo && m_tempo == 1)) begin
                ne = 3; nt = TP;
                if (m_ciclos < 65535) m_ciclos++;
            end else if (tickSegundo) begin
                nt = m_tempo - 1;
            end
        end else begin
            if (tickSegundo) begin
                if (m_tempo == 1) begin ne = 0; nt = 0; end
                else nt = m_tempo - 1;
            end
        end
        m_alarme = m_erro || crit;
        m_valv   = !high && !m_erro && (ne != 4);
        if (sai) begin
            m_run = 0; m_erro = 0;
        end else if (incons) begin
            m_run++;
            if (m_run >= FL) m_erro = 1;
        end else begin
            m_run = 0;
        end
        m_estado = ne;
        m_tempo  = nt;
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic set_levels(input logic [2:0] hml);
        high = hml[2]; mediun = hml[1]; low = hml[0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tickSegundo = 1'b1;
        step();
        reset = 1'b0;
        tickSegundo = 1'b0;
    endtask

    task automatic test_reset();
        reconhecer = 0; umidadeSolo = 0; umidadeAr = 0;
        set_levels(3'b000);
        do_reset();
        checks++;
        if ({gotejamento, aspersao, valvulaEntrada, erro, alarme} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {gotejamento, aspersao, valvulaEntrada, erro, alarme});
        end
        checks++;
        if (estado !== 3'd0 || tempoRestante !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d/%0d exp=0/0", estado, tempoRestante);
        end
    endtask

    task automatic test_gotejo_ciclo();
        int exp_est[7];
        int exp_tmp[7];
        exp_est = '{1, 1, 1, 3, 3, 0, 1};
        exp_tmp = '{3, 2, 1, 2, 1, 0, 3};
        set_levels(3'b111);
        umidadeAr = 1; temperatura = 1; umidadeSolo = 0; reconhecer = 0;
        do_reset();
        tickSegundo = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (estado !== 3'(exp_est[i]) || tempoRestante !== 8'(exp_tmp[i])) begin
                failures++;
                $display("FAIL gotejo_seq[%0d] got=%0d/%0d exp=%0d/%0d", i, estado,
                         tempoRestante, exp_est[i], exp_tmp[i]);
            end
            checks++;
            if (gotejamento !== (exp_est[i] == 1)) begin
                failures++;
                $display("FAIL gotejo_out[%0d] got=%b exp=%b", i, gotejamento, exp_est[i] == 1);
            end
        end
        tickSegundo = 0;
    endtask

    task automatic test_aspersao_solo();
        set_levels(3'b111);
        umidadeAr = 0; umidadeSolo = 0; tickSegundo = 0;
        do_reset();
        step();
        checks++;
        if (aspersao !== 1'b1 || gotejamento !== 1'b0 || tempoRestante !== 8'(TA)) begin
            failures++;
            $display("FAIL aspersao_start got=%b%b/%0d exp=10/%0d", aspersao, gotejamento,
                     tempoRestante, TA);
        end
        tickSegundo = 1;
        step();
        step();
        tickSegundo = 0;
        checks++;
        if (tempoRestante !== 8'(TA - 2)) begin
            failures++;
            $display("FAIL aspersao_dec got=%0d exp=%0d", tempoRestante, TA - 2);
        end
        umidadeSolo = 1;
        step();
        checks++;
        if (aspersao !== 1'b0 || estado !== 3'd3 || tempoRestante !== 8'(TP)) begin
            failures++;
            $display("FAIL aspersao_solo got=%b/%0d/%0d exp=0/3/%0d", aspersao, estado,
                     tempoRestante, TP);
        end
    endtask

    task automatic test_filtro();
        set_levels(3'b111);
        umidadeSolo = 1; umidadeAr = 1; tickSegundo = 0; reconhecer = 0;
        do_reset();
        set_levels(3'b101);
        step();
        step();
        checks++;
        if (erro !== 1'b0) begin
            failures++;
            $display("FAIL filtro_2clk got=%b exp=0", erro);
        end
        set_levels(3'b111);
        step();
        set_levels(3'b101);
        step();
        step();
        checks++;
        if (erro !== 1'b0) begin
            failures++;
            $display("FAIL filtro_run_reset got=%b exp=0", erro);
        end
        step();
        checks++;
        if (erro !== 1'b1) begin
            failures++;
            $display("FAIL filtro_3clk got=%b exp=1", erro);
        end
        set_levels(3'b001);
        step();
        checks++;
        if (estado !== 3'd4 || {gotejamento, aspersao, valvulaEntrada} !== 3'b000
            || alarme !== 1'b1) begin
            failures++;
            $display("FAIL falha_entry got=%0d/%b/%b exp=4/000/1", estado,
                     {gotejamento, aspersao, valvulaEntrada}, alarme);
        end
        step();
        checks++;
        if (estado !== 3'd4 || valvulaEntrada !== 1'b0 || erro !== 1'b1) begin
            failures++;
            $display("FAIL falha_hold got=%0d/%b/%b exp=4/0/1", estado, valvulaEntrada, erro);
        end
        reconhecer = 1;
        set_levels(3'b111);
        step();
        reconhecer = 0;
        checks++;
        if (estado !== 3'd0 || erro !== 1'b0) begin
            failures++;
            $display("FAIL falha_ack got=%0d/%b exp=0/0", estado, erro);
        end
    endtask

    task automatic test_critico();
        set_levels(3'b111);
        umidadeAr = 1; temperatura = 1; umidadeSolo = 0; tickSegundo = 0;
        do_reset();
        step();
        checks++;
        if (estado !== 3'd1) begin
            failures++;
            $display("FAIL critico_pre got=%0d exp=1", estado);
        end
        set_levels(3'b000);
        step();
        checks++;
        if (estado !== 3'd3 || alarme !== 1'b1 || valvulaEntrada !== 1'b1) begin
            failures++;
            $display("FAIL critico_pausa got=%0d/%b/%b exp=3/1/1", estado, alarme,
                     valvulaEntrada);
        end
        tickSegundo = 1;
        for (int i = 0; i < TP + 3; i++) step();
        tickSegundo = 0;
        checks++;
        if (estado !== 3'd0 || gotejamento !== 1'b0) begin
            failures++;
            $display("FAIL critico_ocioso got=%0d/%b exp=0/0", estado, gotejamento);
        end
        set_levels(3'b111);
        step();
        checks++;
        if (estado !== 3'd0 || alarme !== 1'b0) begin
            failures++;
            $display("FAIL critico_clear got=%0d/%b exp=0/0", estado, alarme);
        end
        step();
        checks++;
        if (estado !== 3'd1) begin
            failures++;
            $display("FAIL critico_restart got=%0d exp=1", estado);
        end
    endtask

    task automatic test_prioridade();
        set_levels(3'b111);
        umidadeAr = 1; temperatura = 1; umidadeSolo = 0; tickSegundo = 0;
        do_reset();
        step();
        set_levels(3'b101);
        tickSegundo = 1;
        step();
        step();
        tickSegundo = 0;
        step();
        checks++;
        if (erro !== 1'b1 || estado !== 3'd1 || tempoRestante !== 8'd1) begin
            failures++;
            $display("FAIL prio_setup got=%b/%0d/%0d exp=1/1/1", erro, estado, tempoRestante);
        end
        set_levels(3'b000);
        tickSegundo = 1;
        step();
        tickSegundo = 0;
        checks++;
        if (estado !== 3'd4 || tempoRestante !== 8'd0) begin
            failures++;
            $display("FAIL prio_falha got=%0d/%0d exp=4/0", estado, tempoRestante);
        end
    endtask

    task automatic test_random();
        logic [2:0] boas[4];
        boas = '{3'b111, 3'b011, 3'b001, 3'b000};
        set_levels(3'b111);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            tickSegundo = $urandom_range(0, 1);
            umidadeAr   = $urandom_range(0, 1);
            temperatura = $urandom_range(0, 1);
            umidadeSolo = ($urandom_range(0, 3) == 0);
            reconhecer  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 7) set_levels(boas[$urandom_range(0, 3)]);
            else set_levels(3'($urandom_range(0, 7)));
            step();
            checks++;
            if (estado !== 3'(m_estado) || tempoRestante !== 8'(m_tempo)) begin
                failures++;
                $display("FAIL rnd_estado[%0d] got=%0d/%0d exp=%0d/%0d", i, estado,
                         tempoRestante, m_estado, m_tempo);
            end
            checks++;
            if ({gotejamento, aspersao} !== {m_estado == 1, m_estado == 2}) begin
                failures++;
                $display("FAIL rnd_valvulas[%0d] got=%b%b exp=%b%b", i, gotejamento, aspersao,
                         m_estado == 1, m_estado == 2);
            end
            checks++;
            if ({valvulaEntrada, erro, alarme} !== {m_valv, m_erro, m_alarme}) begin
                failures++;
                $display("FAIL rnd_flags[%0d] got=%b%b%b exp=%b%b%b", i, valvulaEntrada, erro,
                         alarme, m_valv, m_erro, m_alarme);
            end
            checks++;
            if (gotejamento === 1'b1 && aspersao === 1'b1) begin
                failures++;
                $display("FAIL rnd_exclusao[%0d] got=11 exp=not both", i);
            end
`ifdef REGA_CONTADOR_CICLOS_EN
            checks++;
            if (ciclosRega !== 16'(m_ciclos)) begin
                failures++;
                $display("FAIL rnd_ciclos[%0d] got=%0d exp=%0d", i, ciclosRega, m_ciclos);
            end
`endif
        end
        reset = 0;
        reconhecer = 0;
    endtask

`ifdef REGA_CONTADOR_CICLOS_EN
    task automatic test_contador();
        set_levels(3'b111);
        umidadeAr = 1; temperatura = 1; umidadeSolo = 0; reconhecer = 0;
        do_reset();
        tickSegundo = 1;
        for (int i = 0; i < 3 * (TG + TP + 1) - 2; i++) step();
        checks++;
        if (ciclosRega !== 16'd3) begin
            failures++;
            $display("FAIL contador_3 got=%0d exp=3", ciclosRega);
        end
        umidadeAr = 0;
        tickSegundo = 0;
        for (int i = 0; i < 4; i++) step();
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (ciclosRega !== 16'd0 || {gotejamento, aspersao, valvulaEntrada, erro, alarme}
            !== 5'b0 || estado !== 3'd0) begin
            failures++;
            $display("FAIL contador_reset got=%0d/%b/%0d exp=0/00000/0", ciclosRega,
                     {gotejamento, aspersao, valvulaEntrada, erro, alarme}, estado);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_gotejo_ciclo();
        test_aspersao_solo();
        test_filtro();
        test_critico();
        test_prioridade();
        test_random();
`ifdef REGA_CONTADOR_CICLOS_EN
        test_contador();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
